pll_lock_monitor: RTL and testbench

Synthesizable lock detector for the on-chip PLL. It runs on the PLL output clock `CLK`, samples the reference clock `REF` through a synchronizer, and counts `CLK` cycles per `REF` period. Each measurement is compared against the nominal multiplication ratio. It reports a qualified `lock` status, the measured ratio, and a frequency-error direction, which the SoC uses for clock-gating release and debug observation.

---
 rtl/pll_lock_monitor.sv | 140 ++++++++++++++
 tb/tb_pll_lock_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// PLL lock detector: counts CLK cycles per synchronized REF period and qualifies
// lock with consecutive-good / consecutive-bad hysteresis plus a REF-loss timeout.
module pll_lock_monitor #(
   parameter int RATIO      = 8,
   parameter int TOL        = 1,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2,
   parameter int CNT_W      = 8
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             REF,
   output logic             lock,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             too_fast,
   output logic             too_slow,
   output logic             ref_lost
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_CNT + 1);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] LO_LIM  = CNT_W'(RATIO - TOL);
   localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(RATIO + TOL);

   localparam logic [1:0] UNARMED = 2'd0;
   localparam logic [1:0] ACQUIRE = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   logic             ref_s1, ref_s2, ref_s3;
   logic             rise;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       state;
   logic [GW-1:0]    good_cnt;
   logic [BW-1:0]    bad_cnt;
   logic [GW-1:0]    good_inc;
   logic [BW-1:0]    bad_inc;
   logic             good;
   logic             timeout;

   // cnt is the measurement: its value in the rise cycle is the length of the
   // period that just ended, so rise decisions use cnt before it reloads.
   assign rise     = ref_s2 & ~ref_s3;
   assign good     = (cnt >= LO_LIM) && (cnt <= HI_LIM);
   assign timeout  = (state != UNARMED) && (cnt == CNT_MAX) && !rise;
   assign good_inc = good_cnt + GW'(1);
   assign bad_inc  = bad_cnt + BW'(1);

   always_ff @(posedge CLK) begin
      if (reset) begin
         ref_s1 <= 1'b0;
         ref_s2 <= 1'b0;
         ref_s3 <= 1'b0;
      end else begin
         ref_s1 <= REF;
         ref_s2 <= ref_s1;
         ref_s3 <= ref_s2;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset)
         cnt <= '0;
      else if (rise)
         cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)
         cnt <= cnt + CNT_W'(1);
   end

   // The arming rise in UNARMED has no preceding edge, so nothing is published.
   always_ff @(posedge CLK) begin
      if (reset) begin
         period       <= '0;
         period_valid <= 1'b0;
         too_fast     <= 1'b0;
         too_slow     <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (rise && (state != UNARMED)) begin
            period       <= cnt;
            period_valid <= 1'b1;
            too_fast     <= (cnt < LO_LIM);
            too_slow     <= (cnt > HI_LIM);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state    <= UNARMED;
         lock     <= 1'b0;
         good_cnt <= '0;
         bad_cnt  <= '0;
         ref_lost <= 1'b0;
      end else if (timeout) begin
         state    <= UNARMED;
         lock     <= 1'b0;
         ref_lost <= 1'b1;
      end else if (rise) begin
         ref_lost <= 1'b0;
         case (state)
            UNARMED: begin
               state    <= ACQUIRE;
               good_cnt <= '0;
            end
            ACQUIRE: begin
               if (good) begin
                  good_cnt <= good_inc;
                  if (good_inc == GW'(LOCK_CNT)) begin
                     state   <= LOCKED;
                     lock    <= 1'b1;
                     bad_cnt <= '0;
                  end
               end else begin
                  good_cnt <= '0;
               end
            end
            LOCKED: begin
               if (good) begin
                  bad_cnt <= '0;
               end else begin
                  bad_cnt <= bad_inc;
                  if (bad_inc == BW'(UNLOCK_CNT)) begin
                     state    <= ACQUIRE;
                     lock     <= 1'b0;
                     good_cnt <= '0;
                  end
               end
            end
            default: begin
               state <= UNARMED;
               lock  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: drives REF periods of known CLK length
// and checks publish, lock hysteresis, REF-loss timeout, reset and saturation.
module tb_pll_lock_monitor;

   logic       CLK;
   logic       reset;
   logic       REF;
   logic       lock;
   logic [7:0] period;
   logic       period_valid;
   logic       too_fast;
   logic       too_slow;
   logic       ref_lost;

   int errors = 0;
   int checks = 0;

   int         validCount = 0;
   logic [7:0] lastPeriod = '0;
   logic       lockAtLastValid = 1'b0;
   int         baseCount;

   pll_lock_monitor dut (
      .CLK          (CLK),
      .reset        (reset),
      .REF          (REF),
      .lock         (lock),
      .period       (period),
      .period_valid (period_valid),
      .too_fast     (too_fast),
      .too_slow     (too_slow),
      .ref_lost     (ref_lost)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Record every publish pulse so the directed sequence can inspect it later.
   always @(posedge CLK) begin
      #1;
      if (period_valid === 1'b1) begin
         validCount      = validCount + 1;
         lastPeriod      = period;
         lockAtLastValid = lock;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One REF period of p CLK cycles, starting with a rising edge at a negedge.
   task automatic applyStimulus(input int p);
      REF = 1'b1;
      repeat (p / 2) @(negedge CLK);
      REF = 1'b0;
      repeat (p - p / 2) @(negedge CLK);
   endtask

   task automatic applyReset();
      @(negedge CLK);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
   endtask

   task automatic checkAllZero(input string phase);
      checkOutput({phase, "_lock"},         lock,         0);
      checkOutput({phase, "_period"},       period,       0);
      checkOutput({phase, "_period_valid"}, period_valid, 0);
      checkOutput({phase, "_too_fast"},     too_fast,     0);
      checkOutput({phase, "_too_slow"},     too_slow,     0);
      checkOutput({phase, "_ref_lost"},     ref_lost,     0);
   endtask

   initial begin
      reset = 1'b1;
      REF   = 1'b0;
      repeat (3) @(negedge CLK);
      checkAllZero("reset");
      reset = 1'b0;

      $display("[TB] acquire at nominal ratio");
      applyStimulus(8);
      checkOutput("arm_no_valid", validCount, 0);
      applyStimulus(8);
      checkOutput("first_valid_count", validCount, 1);
      checkOutput("first_period", lastPeriod, 8);
      applyStimulus(8);
      applyStimulus(8);
      checkOutput("three_valid_count", validCount, 3);
      checkOutput("no_lock_at_three", lock, 0);
      applyStimulus(8);
      checkOutput("four_valid_count", validCount, 4);
      checkOutput("lock_with_fourth", lockAtLastValid, 1);
      checkOutput("acq_too_fast", too_fast, 0);
      checkOutput("acq_too_slow", too_slow, 0);

      $display("[TB] unlock hysteresis");
      applyStimulus(12);
      applyStimulus(8);
      checkOutput("single_bad_period", lastPeriod, 12);
      checkOutput("single_bad_too_slow", too_slow, 1);
      checkOutput("single_bad_keeps_lock", lock, 1);
      applyStimulus(8);
      checkOutput("recover_too_slow", too_slow, 0);
      checkOutput("recover_keeps_lock", lock, 1);
      applyStimulus(12);
      applyStimulus(12);
      checkOutput("first_of_two_bad_lock", lock, 1);
      applyStimulus(8);
      checkOutput("second_bad_drops_lock", lockAtLastValid, 0);
      checkOutput("unlocked", lock, 0);
      applyStimulus(8);
      applyStimulus(8);
      applyStimulus(8);
      checkOutput("relock_not_yet", lock, 0);
      applyStimulus(8);
      checkOutput("relock", lock, 1);

      $display("[TB] REF loss");
      repeat (200) @(negedge CLK);
      checkOutput("loss_early_ref_lost", ref_lost, 0);
      checkOutput("loss_early_lock", lock, 1);
      for (int i = 0; i < 400 && ref_lost !== 1'b1; i++) @(negedge CLK);
      checkOutput("loss_ref_lost", ref_lost, 1);
      checkOutput("loss_lock", lock, 0);
      baseCount = validCount;
      applyStimulus(8);
      checkOutput("restart_clears_ref_lost", ref_lost, 0);
      checkOutput("restart_no_valid", validCount - baseCount, 0);
      applyStimulus(8);
      applyStimulus(8);
      applyStimulus(8);
      checkOutput("restart_no_lock_yet", lock, 0);
      applyStimulus(8);
      checkOutput("restart_relock", lock, 1);

      $display("[TB] reset while locked");
      applyReset();
      checkAllZero("midreset");
      baseCount = validCount;
      applyStimulus(8);
      checkOutput("midreset_arm_no_valid", validCount - baseCount, 0);
      applyStimulus(8);
      checkOutput("midreset_first_valid", validCount - baseCount, 1);
      checkOutput("midreset_first_period", lastPeriod, 8);

      $display("[TB] tolerance edges 7 and 9");
      applyReset();
      applyStimulus(7);
      applyStimulus(9);
      applyStimulus(7);
      applyStimulus(9);
      applyStimulus(8);
      checkOutput("tol_edges_lock", lock, 1);
      checkOutput("tol_edges_period", lastPeriod, 9);
      checkOutput("tol_edges_too_fast", too_fast, 0);
      checkOutput("tol_edges_too_slow", too_slow, 0);

      $display("[TB] period 6 too fast");
      applyReset();
      repeat (6) applyStimulus(6);
      checkOutput("p6_period", lastPeriod, 6);
      checkOutput("p6_too_fast", too_fast, 1);
      checkOutput("p6_too_slow", too_slow, 0);
      checkOutput("p6_no_lock", lock, 0);

      $display("[TB] period 10 breaks the good run");
      applyReset();
      applyStimulus(8);
      applyStimulus(8);
      applyStimulus(8);
      applyStimulus(10);
      applyStimulus(8);
      checkOutput("p10_period", lastPeriod, 10);
      checkOutput("p10_too_slow", too_slow, 1);
      checkOutput("p10_no_lock", lock, 0);
      applyStimulus(8);
      applyStimulus(8);
      applyStimulus(8);
      checkOutput("p10_count_restarted", lock, 0);
      checkOutput("p10_too_slow_cleared", too_slow, 0);
      applyStimulus(8);
      checkOutput("p10_lock_after_four", lock, 1);

      $display("[TB] saturation race");
      applyReset();
      applyStimulus(8);
      applyStimulus(255);
      applyStimulus(8);
      checkOutput("sat_period", lastPeriod, 255);
      checkOutput("sat_too_slow", too_slow, 1);
      checkOutput("sat_ref_lost", ref_lost, 0);
      checkOutput("sat_no_lock", lock, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
